// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: control codes, widths, FSM states.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CTL_W   = 4;

  // Codes as emitted by the ALU control decoder
  localparam logic [CTL_W-1:0] CTL_AND  = 4'd0;
  localparam logic [CTL_W-1:0] CTL_OR   = 4'd1;
  localparam logic [CTL_W-1:0] CTL_ADD  = 4'd2;
  localparam logic [CTL_W-1:0] CTL_SUB  = 4'd6;
  localparam logic [CTL_W-1:0] CTL_SLT  = 4'd7;
  localparam logic [CTL_W-1:0] CTL_SLTU = 4'd8;
  localparam logic [CTL_W-1:0] CTL_SLL  = 4'd9;
  localparam logic [CTL_W-1:0] CTL_SRL  = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [CTL_W-1:0] ctl);
    return (ctl == CTL_SLL) || (ctl == CTL_SRL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU datapath; shift codes are legal here but produced by the top.
module alu_core
  import alu_pkg::*;
(
  input  logic [CTL_W-1:0]  ctl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y_c,
  output logic              illegal_c
);

  always_comb begin
    y_c       = '0;
    illegal_c = 1'b0;
    case (ctl)
      CTL_AND:  y_c = a & b;
      CTL_OR:   y_c = a | b;
      CTL_ADD:  y_c = a + b;
      CTL_SUB:  y_c = a - b;
      CTL_SLT:  y_c = DATA_W'($signed(a) < $signed(b));
      CTL_SLTU: y_c = DATA_W'(a < b);
      CTL_SLL,
      CTL_SRL:  y_c = '0;
      default:  illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/compare, iterative one-bit-per-cycle shifts,
// valid/ready handshakes on both sides with at most one operation in flight.
module seq_alu
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTL_W-1:0]   alu_ctl,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               illegal
);

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [SHAMT_W-1:0]  cnt;
  logic                shift_left;

  logic [DATA_W-1:0]   core_y;
  logic                core_illegal;
  logic [DATA_W-1:0]   done_val;
  logic [DATA_W-1:0]   shifted;

  alu_core u_core (
    .ctl       (alu_ctl),
    .a         (a),
    .b         (b),
    .y_c       (core_y),
    .illegal_c (core_illegal)
  );

  // Zero-amount shifts pass b straight through on the single-cycle path
  assign done_val = is_shift(alu_ctl) ? b : core_y;
  assign shifted  = shift_left ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b1;
      illegal    <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      shift_left <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_shift(alu_ctl) && (shamt != '0)) begin
              shreg      <= b;
              cnt        <= shamt;
              shift_left <= (alu_ctl == CTL_SLL);
              state      <= SHIFT;
            end else begin
              result    <= done_val;
              zero      <= (done_val == '0);
              illegal   <= core_illegal;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          shreg <= shifted;
          cnt   <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result    <= shifted;
            zero      <= (shifted == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Outputs hold until the consumer takes the result
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table plus hand-written handshake/reset sequences.
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  seq_alu dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y);
    case (ctl)
      4'd0: return x & y;
      4'd1: return x | y;
      4'd2: return x + y;
      4'd6: return x - y;
      4'd7: return (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, x < y};
      4'd8: return {31'd0, x < y};
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where out_valid was first seen high.
  task automatic run_op(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] sh, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    alu_ctl  = ctl;
    a        = x;
    b        = y;
    shamt    = sh;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctl  = 4'd0;
    a        = 32'hDEAD_BEEF;
    b        = 32'hCAFE_F00D;
    shamt    = 5'd0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for out_valid actual=0 required=1");
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("consume_out_valid", 32'(out_valid), 32'd0);
    chk("consume_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic [3:0] ops[6];
    int guard;

    vecs[0]  = '{"add_wrap",   4'd2,  32'hFFFF_FFFF, 32'h1,          5'd0,  32'h0,          1'b0, 1};
    vecs[1]  = '{"sub",        4'd6,  32'd5,         32'd7,          5'd0,  32'hFFFF_FFFE,  1'b0, 1};
    vecs[2]  = '{"slt",        4'd7,  32'hFFFF_FFFF, 32'h1,          5'd0,  32'h1,          1'b0, 1};
    vecs[3]  = '{"sltu",       4'd8,  32'hFFFF_FFFF, 32'h1,          5'd0,  32'h0,          1'b0, 1};
    vecs[4]  = '{"and",        4'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd0,  32'h00F0_00F0,  1'b0, 1};
    vecs[5]  = '{"or",         4'd1,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd0,  32'hFFF0_FFF0,  1'b0, 1};
    vecs[6]  = '{"sll31",      4'd9,  32'h0,         32'h1,          5'd31, 32'h8000_0000,  1'b0, 32};
    vecs[7]  = '{"srl4",       4'd10, 32'h0,         32'h8000_0000,  5'd4,  32'h0800_0000,  1'b0, 5};
    vecs[8]  = '{"sll0",       4'd9,  32'h0,         32'h1234,       5'd0,  32'h1234,       1'b0, 1};
    vecs[9]  = '{"illegal3",   4'd3,  32'h55,        32'h66,         5'd0,  32'h0,          1'b1, 1};
    vecs[10] = '{"add_clears", 4'd2,  32'd1,         32'd2,          5'd7,  32'd3,          1'b0, 1};
    vecs[11] = '{"slt_minmax", 4'd7,  32'h8000_0000, 32'h7FFF_FFFF,  5'd0,  32'h1,          1'b0, 1};
    vecs[12] = '{"sltu_minmx", 4'd8,  32'h8000_0000, 32'h7FFF_FFFF,  5'd0,  32'h0,          1'b0, 1};
    vecs[13] = '{"illegal15",  4'd15, 32'h1,         32'h1,          5'd3,  32'h0,          1'b1, 1};
    vecs[14] = '{"srl1",       4'd10, 32'h0,         32'hF000_0001,  5'd1,  32'h7800_0000,  1'b0, 2};
    vecs[15] = '{"sll_out",    4'd9,  32'h0,         32'h8000_0000,  5'd1,  32'h0,          1'b0, 2};

    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2;
    ops[3] = 4'd6; ops[4] = 4'd7; ops[5] = 4'd8;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctl = 4'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].shamt, lat);
      chk({vecs[i].name, "_result"}, result, vecs[i].exp);
      chk({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].exp == 32'd0));
      chk({vecs[i].name, "_illegal"}, 32'(illegal), 32'(vecs[i].exp_ill));
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      consume();
    end

    // Backpressure: result stable while out_ready held low
    run_op(4'd6, 32'd5, 32'd7, 5'd0, lat);
    held = result;
    chk("bp_result", held, 32'hFFFF_FFFE);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable_result", result, 32'hFFFF_FFFE);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    consume();

    // Reset mid-shift
    alu_ctl = 4'd9; b = 32'h1; shamt = 5'd20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    run_op(4'd2, 32'd1, 32'd1, 5'd0, lat);
    chk("after_rst_add", result, 32'd2);
    consume();

    // in_valid held during SHIFT is accepted only after the result is consumed
    alu_ctl = 4'd9; a = 32'd0; b = 32'h1; shamt = 5'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_ctl = 4'd2; a = 32'd10; b = 32'd20; shamt = 5'd0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("hs_shift_result", result, 32'd8);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hs_in_ready_done", 32'(in_ready), 32'd0);
      chk("hs_held_result", result, 32'd8);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_consume_out_valid", 32'(out_valid), 32'd0);
    chk("hs_consume_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hs_next_out_valid", 32'(out_valid), 32'd1);
    chk("hs_next_result", result, 32'd30);
    consume();

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [3:0]  c;
      logic [31:0] x;
      logic [31:0] y;
      c = ops[$urandom_range(0, 5)];
      x = $urandom;
      y = (i % 3 == 0) ? x : $urandom;
      alu_ctl = c; a = x; b = y; shamt = 5'd0; in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_out_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", result, model(c, x, y));
      chk("b2b_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("b2b_gap_out_valid", 32'(out_valid), 32'd0);
      chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
